bmf_approx_err_monitor: RTL and testbench

- Sequential QoR monitor directly downstream of a BMF-approximated partition, such as the k=3 compressor/decompressor pair of a max-circuit partition.
- Consumes a stream of exact vs approximate partition output words over a valid/ready handshake.
- Over a programmable sample window it accumulates: mismatch count, Hamming-distance sum, absolute-difference sum and maximum absolute difference.
- Provides the per-partition error figures the flow uses to accept or reject a factorization degree k.

---
 rtl/bmf_qor_pkg.sv | 19 +
 rtl/bmf_diff_stage.sv | 47 ++++
 rtl/bmf_approx_err_monitor.sv | 108 ++++++++++
 tb/tb_bmf_approx_err_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmf_qor_pkg.sv
// Shared types and helpers for the BMF approximation QoR monitor.
package bmf_qor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int OUT_W_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int ACC_W_DEF = 24;

    // Unsigned add clamped to the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] s;
        logic [31:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = 32'hFFFF_FFFF >> (32 - w);
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/bmf_diff_stage.sv
// Stage 1: XOR / popcount / absolute difference of one exact-approx pair, registered on handshake.
module bmf_diff_stage #(
    parameter int OUT_W = 4,
    parameter int PC_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs,
    input  logic [OUT_W-1:0] exact_po,
    input  logic [OUT_W-1:0] approx_po,
    output logic             s1_valid,
    output logic [OUT_W-1:0] d_xor,
    output logic [OUT_W-1:0] d_abs,
    output logic [PC_W-1:0]  d_pc
);

    logic [OUT_W-1:0] x_c;
    logic [OUT_W-1:0] abs_c;
    logic [PC_W-1:0]  pc_c;

    always_comb begin
        x_c  = exact_po ^ approx_po;
        pc_c = '0;
        for (int i = 0; i < OUT_W; i++)
            pc_c = pc_c + PC_W'(x_c[i]);
        // Difference of two OUT_W-bit values always fits back into OUT_W bits.
        abs_c = (exact_po >= approx_po) ? OUT_W'({1'b0, exact_po} - {1'b0, approx_po})
                                        : OUT_W'({1'b0, approx_po} - {1'b0, exact_po});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            d_xor    <= '0;
            d_abs    <= '0;
            d_pc     <= '0;
        end else begin
            s1_valid <= hs;
            if (hs) begin
                d_xor <= x_c;
                d_abs <= abs_c;
                d_pc  <= pc_c;
            end
        end
    end

endmodule

// File: rtl/bmf_approx_err_monitor.sv
// Windowed error monitor for a BMF-approximated partition: mismatch count, Hamming sum,
// absolute-difference sum and max absolute difference over num_samples accepted pairs.
module bmf_approx_err_monitor
    import bmf_qor_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] exact_po,
    input  logic [OUT_W-1:0] approx_po,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] hd_sum,
    output logic [ACC_W-1:0] ad_sum,
    output logic [OUT_W-1:0] max_ad
);

    localparam int PC_W = $clog2(OUT_W + 1);

    state_e           state;
    logic [CNT_W-1:0] win_len;
    logic             hs;
    logic             s1_valid;
    logic             s2_valid;
    logic [OUT_W-1:0] d_xor;
    logic [OUT_W-1:0] d_abs;
    logic [PC_W-1:0]  d_pc;

    assign in_ready = (state == RUN) && (sample_cnt < win_len);
    assign hs       = in_valid && in_ready;

    bmf_diff_stage #(.OUT_W(OUT_W), .PC_W(PC_W)) u_diff (
        .clk      (clk),
        .rst_n    (rst_n),
        .hs       (hs),
        .exact_po (exact_po),
        .approx_po(approx_po),
        .s1_valid (s1_valid),
        .d_xor    (d_xor),
        .d_abs    (d_abs),
        .d_pc     (d_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_len    <= '0;
            s2_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            hd_sum     <= '0;
            ad_sum     <= '0;
            max_ad     <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                err_cnt <= CNT_W'(sat_add(32'(err_cnt), 32'(d_xor != '0), CNT_W));
                hd_sum  <= ACC_W'(sat_add(32'(hd_sum), 32'(d_pc), ACC_W));
                ad_sum  <= ACC_W'(sat_add(32'(ad_sum), 32'(d_abs), ACC_W));
                if (d_abs > max_ad)
                    max_ad <= d_abs;
            end
            // Pipeline is empty in IDLE/DONE, so clearing here never races an update.
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        win_len    <= num_samples;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        hd_sum     <= '0;
                        ad_sum     <= '0;
                        max_ad     <= '0;
                    end
                end
                RUN: begin
                    if (hs)
                        sample_cnt <= sample_cnt + CNT_W'(1);
                    if (sample_cnt == win_len)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Wait one extra cycle after the final accumulation so results settle.
                    if (!s1_valid && !s2_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmf_approx_err_monitor.sv
// Scoreboard bench for bmf_approx_err_monitor: randomized windows against an arithmetic model.
module tb_bmf_approx_err_monitor;

    typedef struct {
        int n;
        int err;
        int hd;
        int ad;
        int mx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  exact_po, approx_po;
    logic        busy, done;
    logic [15:0] sample_cnt, err_cnt;
    logic [23:0] hd_sum, ad_sum;
    logic [3:0]  max_ad;

    logic        s_start, s_valid, s_in_ready, s_busy, s_done;
    logic [3:0]  s_num, s_exact, s_approx, s_sample_cnt, s_err, s_max;
    logic [4:0]  s_hd, s_ad;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   pe[64];
    int   pa[64];

    always #5 clk = ~clk;

    bmf_approx_err_monitor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .exact_po(exact_po), .approx_po(approx_po),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .hd_sum(hd_sum), .ad_sum(ad_sum), .max_ad(max_ad)
    );

    bmf_approx_err_monitor #(.OUT_W(4), .CNT_W(4), .ACC_W(5)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .num_samples(s_num),
        .in_valid(s_valid), .in_ready(s_in_ready), .exact_po(s_exact), .approx_po(s_approx),
        .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .err_cnt(s_err),
        .hd_sum(s_hd), .ad_sum(s_ad), .max_ad(s_max)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Monitor: on every rising done, pop the expected window result and compare.
    int   cyc = 0, hs_cnt = 0, rdy_cnt = 0, last_hs = 0, start_cyc = 0;
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            done_q = 1'b0;
            hs_cnt = 0;
            rdy_cnt = 0;
        end else begin
            cyc++;
            if (start && !busy) begin
                start_cyc = cyc;
                hs_cnt = 0;
                rdy_cnt = 0;
            end
            if (in_ready) rdy_cnt++;
            if (in_valid && in_ready) begin
                hs_cnt++;
                last_hs = cyc;
            end
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: done rose with no expected window");
                end else begin
                    e = sb.pop_front();
                    chk("handshakes", hs_cnt, e.n);
                    chk("sample_cnt", sample_cnt, e.n);
                    chk("err_cnt", err_cnt, e.err);
                    chk("hd_sum", hd_sum, e.hd);
                    chk("ad_sum", ad_sum, e.ad);
                    chk("max_ad", max_ad, e.mx);
                    chk("busy_at_done", busy, 0);
                    // done 3 edges after the last handshake (sampled one negedge ahead),
                    // or 2 edges after start for an empty window.
                    if (e.n > 0) chk("done_latency", cyc - last_hs, 4);
                    else begin
                        chk("done_latency0", cyc - start_cyc, 3);
                        chk("ready_cycles0", rdy_cnt, 0);
                    end
                end
            end
            done_q = done;
        end
    end

    task automatic gen_pairs(input int n, input int kind);
        for (int i = 0; i < n; i++) begin
            pe[i] = $urandom_range(0, 15);
            pa[i] = (kind == 1) ? (pe[i] ^ 15) : $urandom_range(0, 15);
        end
    endtask

    // mode 0: valid always high, 1: alternating 1,0,1.., 2: random.
    task automatic run_window(input int n, input int mode, input int poke);
        exp_t x;
        int   i, budget, phase, d;
        logic hs;
        x.n = n; x.err = 0; x.hd = 0; x.ad = 0; x.mx = 0;
        for (int k = 0; k < n; k++) begin
            d = pe[k] ^ pa[k];
            if (d != 0) x.err++;
            x.hd += $countones(d[3:0]);
            x.ad += absdiff(pe[k], pa[k]);
            if (absdiff(pe[k], pa[k]) > x.mx) x.mx = absdiff(pe[k], pa[k]);
        end
        if (x.err > 65535) x.err = 65535;
        if (x.hd > 24'hFFFFFF) x.hd = 24'hFFFFFF;
        if (x.ad > 24'hFFFFFF) x.ad = 24'hFFFFFF;
        sb.push_back(x);

        @(posedge clk); #1;
        start = 1'b1;
        num_samples = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_busy", busy, 1);
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_ad_sum", ad_sum, 0);
        chk("clr_max_ad", max_ad, 0);

        i = 0; budget = 0; phase = 1;
        while (i < n && budget < 400) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = phase[0];
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            phase = 1 - phase;
            exact_po  = in_valid ? 4'(pe[i]) : 4'($urandom_range(0, 15));
            approx_po = in_valid ? 4'(pa[i]) : 4'($urandom_range(0, 15));
            if (poke != 0 && i == n / 2 && budget > 0 && budget < 3) begin
                start = 1'b1;
                num_samples = 16'($urandom_range(0, 40));
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) i++;
            budget++;
        end
        in_valid = 1'b0;
        if (i < n) chk("hs_timeout", i, n);
        budget = 0;
        while (!done && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        int k, b;
        logic hs;
        int sh, sa, sm;
        rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        exact_po = '0; approx_po = '0;
        s_start = 1'b0; s_valid = 1'b0; s_num = '0; s_exact = '0; s_approx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_hd_sum", hd_sum, 0);
        chk("rst_max_ad", max_ad, 0);
        @(negedge clk) rst_n = 1'b1;

        pe[0] = 5; pa[0] = 5; pe[1] = 3; pa[1] = 5; pe[2] = 9; pa[2] = 6; pe[3] = 0; pa[3] = 15;
        run_window(4, 0, 0);
        run_window(0, 0, 0);
        gen_pairs(3, 0);
        run_window(3, 1, 0);
        gen_pairs(15, 1);
        run_window(15, 0, 0);
        gen_pairs(5, 0);
        run_window(5, 0, 1);
        pe[0] = 2; pa[0] = 1;
        run_window(1, 0, 0);
        for (int w = 0; w < 12; w++) begin
            k = $urandom_range(0, 20);
            gen_pairs(k, $urandom_range(0, 3) == 0 ? 1 : 0);
            run_window(k, $urandom_range(0, 2), $urandom_range(0, 1));
        end

        // Reset in the middle of a window after two samples.
        @(posedge clk); #1;
        start = 1'b1; num_samples = 16'd6;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; exact_po = 4'd1; approx_po = 4'd6;
        k = 0; b = 0;
        while (k < 2 && b < 20) begin
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            b++;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_ad_sum", ad_sum, 10);
        chk("pre_rst_sample_cnt", sample_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sample_cnt", sample_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_hd_sum", hd_sum, 0);
        chk("mid_rst_ad_sum", ad_sum, 0);
        chk("mid_rst_max_ad", max_ad, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        pe[0] = 2; pa[0] = 1;
        run_window(1, 0, 0);

        // Narrow instance: Hamming and abs-diff sums clamp at 31.
        gen_pairs(15, 1);
        sh = 0; sa = 0; sm = 0;
        for (int i = 0; i < 15; i++) begin
            sh += 4;
            sa += absdiff(pe[i], pa[i]);
            if (absdiff(pe[i], pa[i]) > sm) sm = absdiff(pe[i], pa[i]);
        end
        if (sh > 31) sh = 31;
        if (sa > 31) sa = 31;
        @(posedge clk); #1;
        s_start = 1'b1; s_num = 4'd15;
        @(posedge clk); #1;
        s_start = 1'b0;
        k = 0; b = 0;
        while (k < 15 && b < 60) begin
            s_valid = 1'b1;
            s_exact = 4'(pe[k]);
            s_approx = 4'(pa[k]);
            hs = s_valid && s_in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            b++;
        end
        s_valid = 1'b0;
        b = 0;
        while (!s_done && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        chk("sat_done", s_done, 1);
        chk("sat_sample_cnt", s_sample_cnt, 15);
        chk("sat_err_cnt", s_err, 15);
        chk("sat_hd_sum", s_hd, sh);
        chk("sat_ad_sum", s_ad, sa);
        chk("sat_max_ad", s_max, sm);

        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
